// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch stage: default width, FSM states and
// the buffered entry layout {ins, pc, fault}.
package ifetch_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDiscard
  } state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] ins;
    logic [XLEN_DEF-1:0] pc;
    logic                fault;
  } entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: power-of-two FIFO with wrap-around pointers, synchronous
// flush and an occupancy count.
module ifetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 65,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic            pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CntW-1:0] count_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_pop;

  assign w_pop   = pop_i & (r_count != '0);
  assign data_o  = r_mem[r_rptr];
  assign count_o = r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      unique case ({push_i, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only slots below count are ever presented.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding memory read at a time, results and
// misaligned-fetch faults queued in a small FIFO for the decode stage.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_v_i,
  input  logic            pc_aligned_i,
  output logic            pc_adv_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] ins_o,
  output logic [XLEN-1:0] ins_pc_o,
  output logic            ins_fault_o,
  output logic            ins_v_o,
  input  logic            ins_rdy_i
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned EntW = 2 * XLEN + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [XLEN-1:0]   r_addr;
  logic [CntW-1:0]   w_count;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [EntW-1:0]   w_push_data;
  logic [EntW-1:0]   w_head;

  // Accepting only with a free slot reserves room for the eventual push.
  assign w_accept = rst_ni & (r_state == StIdle) & pc_v_i & (w_count < CntW'(DEPTH)) & ~flush_i;
  assign pc_adv_o = w_accept;

  assign w_push = ~flush_i & (((r_state == StWait) & mem_ack_i) | (w_accept & ~pc_aligned_i));
  // Packed in entry_t field order {ins, pc, fault}.
  assign w_push_data = (r_state == StWait) ? {mem_rdata_i, r_addr, 1'b0}
                                           : {{XLEN{1'b0}}, pc_i, 1'b1};

  assign ins_v_o = (w_count != '0) & ~flush_i;
  assign w_pop   = ins_v_o & ins_rdy_i;
  assign {ins_o, ins_pc_o, ins_fault_o} = w_head;

  assign mem_req_o  = (r_state != StIdle);
  assign mem_addr_o = r_addr;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept && pc_aligned_i) w_state_nxt = StWait;
      end
      StWait: begin
        if (mem_ack_i)    w_state_nxt = StIdle;
        else if (flush_i) w_state_nxt = StDiscard;
      end
      StDiscard: begin
        if (mem_ack_i) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && pc_aligned_i) r_addr <= pc_i;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_count)
  );

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: table-driven fetch vectors plus hand-written
// flush/backpressure/reset sequences, all results checked through a scoreboard.
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] pc_i;
  logic        pc_v_i;
  logic        pc_aligned_i;
  logic        pc_adv_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        flush_i;
  logic [31:0] ins_o;
  logic [31:0] ins_pc_o;
  logic        ins_fault_o;
  logic        ins_v_o;
  logic        ins_rdy_i;

  logic        ack_en;
  logic        rdata_ovr;

  int checks   = 0;
  int failures = 0;
  entry_t exp_q[$];

  typedef struct {
    logic [31:0] pc;
    logic        al;
    logic [31:0] ins;
    int          n_wait;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  ifetch #(
    .XLEN  (32),
    .DEPTH (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .pc_i         (pc_i),
    .pc_v_i       (pc_v_i),
    .pc_aligned_i (pc_aligned_i),
    .pc_adv_o     (pc_adv_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .flush_i      (flush_i),
    .ins_o        (ins_o),
    .ins_pc_o     (ins_pc_o),
    .ins_fault_o  (ins_fault_o),
    .ins_v_o      (ins_v_o),
    .ins_rdy_i    (ins_rdy_i)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h11 * ((a >> 2) + 32'd1);
  endfunction

  // Memory model: acks in the first request cycle whenever enabled.
  assign mem_ack_i   = mem_req_o & ack_en;
  assign mem_rdata_i = rdata_ovr ? 32'hDEAD : mem_word(mem_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: compares every pop handshake against the queue head.
  always @(negedge clk) begin
    entry_t e;
    if (!rst_ni) begin
      exp_q.delete();
    end else if (flush_i) begin
      chk("flush_ins_v", {31'd0, ins_v_o}, 32'd0);
      exp_q.delete();
    end else if (ins_v_o && ins_rdy_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got ins=%h pc=%h expected no entry", ins_o, ins_pc_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_ins", ins_o, e.ins);
        chk("sb_pc", ins_pc_o, e.pc);
        chk("sb_fault", {31'd0, ins_fault_o}, {31'd0, e.fault});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one pc, waits (bounded) for acceptance, checks the stall count and
  // pushes the expected entry. Called and returns at posedge+1.
  task automatic fetch(input logic [31:0] pc, input logic al, input logic [31:0] ins,
                       input int exp_wait);
    int n = 0;
    entry_t e;
    pc_i = pc;
    pc_aligned_i = al;
    pc_v_i = 1'b1;
    @(negedge clk);
    while (!pc_adv_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!pc_adv_o) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: pc=%h got no pc_adv_o expected accept", pc);
    end else begin
      chk("accept_wait", n, exp_wait);
      e.ins = ins;
      e.pc = pc;
      e.fault = ~al;
      exp_q.push_back(e);
    end
    tick();
    pc_v_i = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h00, 1'b1, 32'h11, 0};
    vecs[1] = '{32'h04, 1'b1, 32'h22, 1};
    vecs[2] = '{32'h08, 1'b1, 32'h33, 1};
    vecs[3] = '{32'h01, 1'b0, 32'h00, 1};
    vecs[4] = '{32'h10, 1'b1, 32'h55, 0};
    vecs[5] = '{32'h03, 1'b0, 32'h00, 1};
    vecs[6] = '{32'h06, 1'b0, 32'h00, 0};

    rst_ni = 1'b0;
    pc_i = 32'h0;
    pc_v_i = 1'b1;
    pc_aligned_i = 1'b1;
    flush_i = 1'b0;
    ins_rdy_i = 1'b1;
    ack_en = 1'b1;
    rdata_ovr = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ins_v", {31'd0, ins_v_o}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_pc_adv", {31'd0, pc_adv_o}, 32'd0);
    tick();
    rst_ni = 1'b1;

    // Table: back-to-back fetches, aligned and misaligned
    for (int i = 0; i < 7; i++) fetch(vecs[i].pc, vecs[i].al, vecs[i].ins, vecs[i].n_wait);
    repeat (3) tick();

    // Misaligned: fault entry next cycle, no memory request
    ins_rdy_i = 1'b0;
    fetch(32'h1, 1'b0, 32'h0, 0);
    @(negedge clk);
    chk("mis_ins_v", {31'd0, ins_v_o}, 32'd1);
    chk("mis_fault", {31'd0, ins_fault_o}, 32'd1);
    chk("mis_pc", ins_pc_o, 32'h1);
    chk("mis_mem_req", {31'd0, mem_req_o}, 32'd0);
    tick();
    ins_rdy_i = 1'b1;
    repeat (2) tick();

    // Backpressure: DEPTH entries buffered, then stall until a pop
    ins_rdy_i = 1'b0;
    fetch(32'h70, 1'b1, mem_word(32'h70), 0);
    fetch(32'h74, 1'b1, mem_word(32'h74), 1);
    pc_i = 32'h78;
    pc_v_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_pc_adv", {31'd0, pc_adv_o}, 32'd0);
      chk("full_mem_req", {31'd0, mem_req_o}, 32'd0);
      tick();
    end
    ins_rdy_i = 1'b1;
    fetch(32'h78, 1'b1, mem_word(32'h78), 1);
    repeat (4) tick();

    // Flush in WAIT; late ack with 0xDEAD must be discarded
    ack_en = 1'b0;
    fetch(32'h30, 1'b1, mem_word(32'h30), 0);
    flush_i = 1'b1;
    rdata_ovr = 1'b1;
    @(negedge clk);
    chk("fl_mem_req", {31'd0, mem_req_o}, 32'd1);
    tick();
    flush_i = 1'b0;
    pc_i = 32'h34;
    pc_aligned_i = 1'b1;
    pc_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ack_en = 1'b1;
      @(negedge clk);
      chk("disc_pc_adv", {31'd0, pc_adv_o}, 32'd0);
      chk("disc_mem_req", {31'd0, mem_req_o}, 32'd1);
      chk("disc_ins_v", {31'd0, ins_v_o}, 32'd0);
      tick();
    end
    rdata_ovr = 1'b0;
    fetch(32'h34, 1'b1, mem_word(32'h34), 0);
    repeat (3) tick();

    // Flush coincident with ack and a pop handshake
    ins_rdy_i = 1'b0;
    fetch(32'h50, 1'b1, mem_word(32'h50), 0);
    tick();
    ack_en = 1'b0;
    fetch(32'h54, 1'b1, mem_word(32'h54), 0);
    flush_i = 1'b1;
    ack_en = 1'b1;
    ins_rdy_i = 1'b1;
    @(negedge clk);
    chk("flack_mem_req", {31'd0, mem_req_o}, 32'd1);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    chk("flack_empty", {31'd0, ins_v_o}, 32'd0);
    chk("flack_idle", {31'd0, mem_req_o}, 32'd0);
    tick();
    fetch(32'h58, 1'b1, mem_word(32'h58), 0);
    repeat (3) tick();

    // Reset mid-WAIT with a buffered entry, then a clean fetch at 0x40
    ins_rdy_i = 1'b0;
    ack_en = 1'b0;
    fetch(32'h61, 1'b0, 32'h0, 0);
    fetch(32'h64, 1'b1, mem_word(32'h64), 0);
    pc_i = 32'h40;
    pc_aligned_i = 1'b1;
    pc_v_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mrst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("mrst_ins_v", {31'd0, ins_v_o}, 32'd0);
    chk("mrst_pc_adv", {31'd0, pc_adv_o}, 32'd0);
    @(negedge clk);
    tick();
    rst_ni = 1'b1;
    ins_rdy_i = 1'b1;
    ack_en = 1'b1;
    fetch(32'h40, 1'b1, 32'h121, 0);
    @(negedge clk);
    chk("lat_mem_req", {31'd0, mem_req_o}, 32'd1);
    chk("lat_mem_addr", mem_addr_o, 32'h40);
    chk("lat_ins_v0", {31'd0, ins_v_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("lat_ins_v1", {31'd0, ins_v_o}, 32'd1);
    chk("lat_ins", ins_o, 32'h121);
    chk("lat_pc", ins_pc_o, 32'h40);
    repeat (4) tick();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
